int_to_flt: RTL and testbench

Multi-cycle converter from 16-bit two's-complement integer to half-precision float (1 sign, 5 exponent bits with bias 15, 10 mantissa bits, hidden 1). It is the upstream stage of the float adder: it produces the operand words the adder reads as byte pairs. The high byte is sign, exponent and mant[9:8]; the low byte is mant[7:0]. Normalization is iterative, one bit per cycle, under a start/done handshake.

---
 rtl/flt_pkg.sv | 24 ++
 rtl/flt_round.sv | 40 ++++
 rtl/int_to_flt.sv | 85 ++++++++
 tb/tb_int_to_flt.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/flt_pkg.sv
// Shared float-format definitions for the int_to_flt converter and the float adder.
package flt_pkg;

    localparam int EXP_BIAS = 15;
    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int FLT_W    = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Half-precision word; the high byte is {sign, exp, mant[9:8]}.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } flt_t;

endpackage

// File: rtl/flt_round.sv
// GRS rounding with mantissa carry into the exponent. Shared with the float adder.
// FLT_ROUND_EN selects round-to-nearest-even; without it the mantissa is truncated.
module flt_round
    import flt_pkg::*;
(
    input  logic              sign,
    input  logic [EXP_W-1:0]  exp,
    input  logic [MANT_W-1:0] mant,
    input  logic              guard,
    input  logic              rnd,
    input  logic              sticky,
    output flt_t              res
);

    logic            inc;
    logic [MANT_W:0] mant_sum;

`ifdef FLT_ROUND_EN
    assign inc = guard & (rnd | sticky | mant[0]);
`else
    // Truncation ignores the guard/round/sticky bits entirely.
    logic unused_grs;
    assign unused_grs = guard ^ rnd ^ sticky;
    assign inc = 1'b0;
`endif

    assign mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};

    // Carry out of the mantissa renormalizes: mantissa wraps to zero, exponent bumps.
    always_comb begin
        res.sign = sign;
        res.exp  = exp;
        res.mant = mant_sum[MANT_W-1:0];
        if (mant_sum[MANT_W]) begin
            res.mant = '0;
            res.exp  = exp + 1'b1;
        end
    end

endmodule

// File: rtl/int_to_flt.sv
// 16-bit signed integer to half-precision float, normalizing one bit per cycle.
// Build option: define FLT_ROUND_EN for round-to-nearest-even (default truncates).
module int_to_flt
    import flt_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [FLT_W-1:0] int_in,
    output logic [FLT_W-1:0] flt_out,
    output logic             done,
    output logic             busy
);

    state_t           state, next_state;
    logic [FLT_W-1:0] int_q;
    logic [FLT_W-1:0] mag_abs;
    logic [FLT_W-1:0] mag;
    logic [3:0]       shift;
    logic             sign;
    logic             zero;
    logic [EXP_W-1:0] exp_pre;
    flt_t             rounded;

    // Two's-complement magnitude; -32768 naturally maps to 16'h8000.
    assign mag_abs = int_q[FLT_W-1] ? (~int_q + 1'b1) : int_q;
    assign exp_pre = 5'd30 - {1'b0, shift};

    flt_round u_round (
        .sign   (sign),
        .exp    (exp_pre),
        .mant   (mag[14:5]),
        .guard  (mag[4]),
        .rnd    (mag[3]),
        .sticky (|mag[2:0]),
        .res    (rounded)
    );

    // Next-state logic; start only matters when idle or holding a result.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = LOAD;
            LOAD:       next_state = (mag_abs == '0) ? ROUND : NORM;
            NORM:       if (mag[15]) next_state = ROUND;
            ROUND:      next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // State register, registered status outputs and the datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            int_q   <= '0;
            mag     <= '0;
            shift   <= '0;
            sign    <= 1'b0;
            zero    <= 1'b0;
            flt_out <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == LOAD) || (next_state == NORM) || (next_state == ROUND);
            done  <= (next_state == DONE);
            case (state)
                IDLE, DONE: if (start) int_q <= int_in;
                LOAD: begin
                    sign  <= int_q[FLT_W-1];
                    mag   <= mag_abs;
                    shift <= '0;
                    zero  <= (mag_abs == '0);
                end
                NORM: if (!mag[15]) begin
                    mag   <= mag << 1;
                    shift <= shift + 1'b1;
                end
                ROUND: flt_out <= zero ? '0 : rounded;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_flt.sv
// Self-checking bench for int_to_flt; honours FLT_ROUND_EN the same way as the RTL build.
module tb_int_to_flt;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] int_in;
    logic [15:0] flt_out;
    logic        done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int_to_flt dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .int_in  (int_in),
        .flt_out (flt_out),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference: value-level conversion from the float format definition.
    function automatic logic [15:0] ref_flt(input logic [15:0] v, output int lat);
        int iv, m, p, trunc, rem, half;
        logic sgn;
        iv  = int'($signed(v));
        sgn = (iv < 0);
        m   = sgn ? -iv : iv;
        if (m == 0) begin
            lat = 2;
            return 16'h0000;
        end
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        lat = 3 + (15 - p);
        if (p <= 10) begin
            trunc = m << (10 - p);
        end else begin
            trunc = m >> (p - 10);
            rem   = m - (trunc << (p - 10));
            half  = 1 << (p - 11);
`ifdef FLT_ROUND_EN
            if (rem > half || (rem == half && (trunc % 2) == 1)) trunc++;
`endif
            if (trunc == 2048) begin
                trunc = 1024;
                p++;
            end
        end
        return {sgn, 5'(p + 15), 10'(trunc)};
    endfunction

    // Issue one conversion from IDLE/DONE and time it. hs_bad flags any cycle
    // where busy/done disagree (busy must be exactly !done until done rises).
    task automatic do_conv(input logic [15:0] v, output logic [15:0] res,
                           output int lat, output bit hs_bad, output bit tmo);
        hs_bad = 0;
        tmo    = 1;
        lat    = 0;
        start  = 1'b1;
        int_in = v;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        int_in = 16'($urandom);
        if (done || !busy) hs_bad = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy == done) hs_bad = 1;
            if (done) begin
                tmo = 0;
                break;
            end
        end
        res = flt_out;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        int_in = 16'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({flt_out, done, busy} !== 18'h0) begin
            errors++;
            $display("FAIL reset: flt=%h done=%b busy=%b, want 0000 0 0", flt_out, done, busy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] vals [8] = '{16'd1, 16'hFFFF, 16'd0, 16'h8000, 16'd2051, 16'd2049, 16'd32767, 16'd2048};
`ifdef FLT_ROUND_EN
        logic [15:0] exps [8] = '{16'h3C00, 16'hBC00, 16'h0000, 16'hF800, 16'h6802, 16'h6800, 16'h7800, 16'h6800};
`else
        logic [15:0] exps [8] = '{16'h3C00, 16'hBC00, 16'h0000, 16'hF800, 16'h6801, 16'h6800, 16'h77FF, 16'h6800};
`endif
        int lats [8] = '{18, 18, 2, 3, 7, 7, 4, 7};
        logic [15:0] r;
        int lat;
        bit hb, to;
        for (int i = 0; i < 8; i++) begin
            do_conv(vals[i], r, lat, hb, to);
            checks++;
            if (to || r !== exps[i] || lat != lats[i] || hb) begin
                errors++;
                $display("FAIL directed %h: flt=%h lat=%0d hs=%b to=%b, want %h lat=%0d", vals[i], r, lat, hb, to, exps[i], lats[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] v, r, e;
        int lat, elat;
        bit hb, to;
        for (int i = 0; i < 80; i++) begin
            v = 16'($urandom);
            if (i % 4 == 1) v = 16'($urandom_range(0, 40));
            if (i % 4 == 2) v = 16'($urandom_range(1024, 4096)) ^ {16{v[0]}};
            e = ref_flt(v, elat);
            do_conv(v, r, lat, hb, to);
            checks++;
            if (to || r !== e || lat != elat || hb) begin
                errors++;
                $display("FAIL random %h: flt=%h lat=%0d hs=%b to=%b, want %h lat=%0d", v, r, lat, hb, to, e, elat);
            end
        end
    endtask

    // Re-pulse start and change int_in mid-NORM; the first result must not move.
    task automatic test_restart_mid_norm();
        int lat = 0;
        bit ok = 0;
        start  = 1'b1;
        int_in = 16'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) begin
                start  = 1'b1;
                int_in = 16'd5;
            end
            if (i == 6) begin
                start  = 1'b0;
                int_in = 16'h7ABC;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (!ok || flt_out !== 16'h3C00 || lat != 18) begin
            errors++;
            $display("FAIL restart_mid_norm: flt=%h lat=%0d done=%b, want 3c00 lat=18", flt_out, lat, ok);
        end
    endtask

    // From DONE, a new start is taken on the next edge and done drops for the new latency.
    task automatic test_back_to_back();
        logic [15:0] r;
        int lat;
        bit hb, to;
        do_conv(16'd2048, r, lat, hb, to);
        checks++;
        if (to || r !== 16'h6800 || lat != 7 || hb) begin
            errors++;
            $display("FAIL back_to_back: flt=%h lat=%0d hs=%b to=%b, want 6800 lat=7", r, lat, hb, to);
        end
    endtask

    task automatic test_reset_mid_norm();
        logic [15:0] r;
        int lat;
        bit hb, to;
        start  = 1'b1;
        int_in = 16'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || flt_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_norm: flt=%h done=%b busy=%b, want 0000 0 0", flt_out, done, busy);
        end
        do_conv(16'd2050, r, lat, hb, to);
        checks++;
        if (to || r !== 16'h6801 || lat != 7 || hb) begin
            errors++;
            $display("FAIL after_reset 2050: flt=%h lat=%0d hs=%b to=%b, want 6801 lat=7", r, lat, hb, to);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_restart_mid_norm();
        test_back_to_back();
        test_reset_mid_norm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
